// File: rtl/axis_mon_pkg.sv
// rtl/axis_mon_pkg.sv - shared constants and status record for the rx frame monitor
// Contents: default frame length limits, status length width, status record type.
package axis_mon_pkg;

    localparam int DEF_MIN_FRAME  = 64;
    localparam int DEF_MAX_FRAME  = 1518;
    localparam int STAT_LEN_WIDTH = 16;

    typedef struct packed {
        logic [STAT_LEN_WIDTH-1:0] len;
        logic                      runt;
        logic                      oversize;
    } stat_rec_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered skid buffer carrying tdata and tlast
// Ports: clk, srst (sync, active-high); in_* upstream beat with registered in_trdy;
//        out_* downstream beat, out_trdy from consumer.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tlast,
    input  logic                  in_tvalid,
    output logic                  in_trdy,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tlast,
    output logic                  out_tvalid,
    input  logic                  out_trdy
);

    logic [DATA_WIDTH:0] mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;
    logic [1:0]          count_next;
    logic                trdy_q;
    logic                push;
    logic                pop;

    assign in_trdy    = trdy_q;
    assign out_tvalid = (count != 2'd0);
    assign out_tdata  = mem[rd_ptr][DATA_WIDTH-1:0];
    assign out_tlast  = mem[rd_ptr][DATA_WIDTH];

    assign push       = in_tvalid & trdy_q;
    assign pop        = out_tvalid & out_trdy;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (srst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            trdy_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_tlast, in_tdata};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count  <= count_next;
            // Ready is registered from the next occupancy so upstream never sees a comb path.
            trdy_q <= (count_next <= 2'd1);
        end
    end

endmodule

// File: rtl/axis_rx_frame_monitor.sv
// rtl/axis_rx_frame_monitor.sv - pass-through stream monitor reporting per-frame length and class
// Ports: m_aclk, m_sreset (sync, active-high); s_axis_* upstream; m_axis_* downstream;
//        stat_len/stat_runt/stat_oversize/stat_valid/stat_rdy status record; frame_cnt.
module axis_rx_frame_monitor
    import axis_mon_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8,
    parameter int MIN_FRAME      = DEF_MIN_FRAME,
    parameter int MAX_FRAME      = DEF_MAX_FRAME,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                      m_aclk,
    input  logic                      m_sreset,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_trdy,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_trdy,
    output logic [LEN_WIDTH-1:0]      stat_len,
    output logic                      stat_runt,
    output logic                      stat_oversize,
    output logic                      stat_valid,
    input  logic                      stat_rdy,
    output logic [31:0]               frame_cnt
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    logic                 buf_trdy;
    logic                 stall;
    logic                 accept;
    logic                 accept_last;
    logic [LEN_WIDTH-1:0] byte_cnt;
    logic [LEN_WIDTH-1:0] cnt_inc;
    stat_rec_t            rec_d;
    stat_rec_t            rec_q;
    logic                 stat_valid_q;
    logic [31:0]          frame_cnt_q;

    // A last beat cannot complete while the single status slot is still occupied.
    assign stall       = s_axis_tvalid & s_axis_tlast & stat_valid_q & ~stat_rdy;
    assign s_axis_trdy = buf_trdy & ~stall;
    assign accept      = s_axis_tvalid & s_axis_trdy;
    assign accept_last = accept & s_axis_tlast;

    assign cnt_inc = (byte_cnt == LEN_MAX) ? byte_cnt : byte_cnt + LEN_WIDTH'(1);

    always_comb begin
        rec_d          = '0;
        rec_d.len      = cnt_inc;
        rec_d.runt     = (32'(cnt_inc) < MIN_FRAME);
        rec_d.oversize = (32'(cnt_inc) > MAX_FRAME);
    end

    always_ff @(posedge m_aclk) begin
        if (m_sreset) begin
            byte_cnt     <= '0;
            rec_q        <= '0;
            stat_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            if (accept) begin
                byte_cnt <= s_axis_tlast ? '0 : cnt_inc;
            end
            // A reload on the same edge as a consume keeps the slot full.
            if (accept_last) begin
                rec_q        <= rec_d;
                stat_valid_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + 32'd1;
            end else if (stat_rdy) begin
                stat_valid_q <= 1'b0;
            end
        end
    end

    assign stat_len      = rec_q.len;
    assign stat_runt     = rec_q.runt;
    assign stat_oversize = rec_q.oversize;
    assign stat_valid    = stat_valid_q;
    assign frame_cnt     = frame_cnt_q;

    axis_skid_buffer #(
        .DATA_WIDTH(AXI_DATA_WIDTH)
    ) u_skid (
        .clk       (m_aclk),
        .srst      (m_sreset),
        .in_tdata  (s_axis_tdata),
        .in_tlast  (s_axis_tlast),
        .in_tvalid (s_axis_tvalid & ~stall),
        .in_trdy   (buf_trdy),
        .out_tdata (m_axis_tdata),
        .out_tlast (m_axis_tlast),
        .out_tvalid(m_axis_tvalid),
        .out_trdy  (m_axis_trdy)
    );

endmodule

// File: tb/tb_axis_rx_frame_monitor.sv
// tb/tb_axis_rx_frame_monitor.sv - scoreboard bench for axis_rx_frame_monitor
module tb_axis_rx_frame_monitor;

    localparam int DW    = 8;
    localparam int MINF  = 64;
    localparam int MAXF  = 1518;
    localparam int LW    = 16;
    localparam int BOUND = 400;

    logic          m_aclk        = 1'b0;
    logic          m_sreset      = 1'b1;
    logic [DW-1:0] s_axis_tdata  = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast  = 1'b0;
    logic          s_axis_trdy;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_trdy   = 1'b1;
    logic [LW-1:0] stat_len;
    logic          stat_runt;
    logic          stat_oversize;
    logic          stat_valid;
    logic          stat_rdy      = 1'b1;
    logic [31:0]   frame_cnt;

    int          n_checks   = 0;
    int          n_pass     = 0;
    logic [8:0]  sb_data[$];
    logic [17:0] sb_stat[$];
    int          acc_total  = 0;
    int          pop_total  = 0;
    int          exp_frames = 0;
    int          stat_seen  = 0;
    bit          rand_mtrdy = 0;
    bit          rand_srdy  = 0;

    axis_rx_frame_monitor #(
        .AXI_DATA_WIDTH(DW),
        .MIN_FRAME     (MINF),
        .MAX_FRAME     (MAXF),
        .LEN_WIDTH     (LW)
    ) dut (
        .m_aclk       (m_aclk),
        .m_sreset     (m_sreset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_trdy  (s_axis_trdy),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_trdy  (m_axis_trdy),
        .stat_len     (stat_len),
        .stat_runt    (stat_runt),
        .stat_oversize(stat_oversize),
        .stat_valid   (stat_valid),
        .stat_rdy     (stat_rdy),
        .frame_cnt    (frame_cnt)
    );

    initial forever #5 m_aclk = ~m_aclk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference record: length saturates at the counter width, then classified by the limits.
    function automatic logic [17:0] exp_rec(input int n);
        int         l;
        logic [15:0] l16;
        logic       ov;
        logic       ru;
        l   = (n > 65535) ? 65535 : n;
        l16 = l[15:0];
        ov  = (l > MAXF);
        ru  = (l < MINF);
        return {ov, ru, l16};
    endfunction

    // Monitor: pops the scoreboards on every downstream / status transfer.
    initial begin
        logic [8:0]  ed;
        logic [17:0] es;
        forever begin
            @(negedge m_aclk);
            if (m_sreset) begin
                acc_total = 0;
                pop_total = 0;
            end else begin
                if (acc_total - pop_total >= 2) chk("s_axis_trdy_when_full", s_axis_trdy, 0);
                if (s_axis_tvalid && s_axis_trdy) acc_total++;
                if (m_axis_tvalid && m_axis_trdy) begin
                    pop_total++;
                    if (sb_data.size() == 0) chk("unexpected_m_axis_beat", 1, 0);
                    else begin
                        ed = sb_data.pop_front();
                        chk("m_axis_beat", {m_axis_tlast, m_axis_tdata}, ed);
                    end
                end
                if (stat_valid && stat_rdy) begin
                    stat_seen++;
                    if (sb_stat.size() == 0) chk("unexpected_stat_record", 1, 0);
                    else begin
                        es = sb_stat.pop_front();
                        chk("stat_record", {stat_oversize, stat_runt, stat_len}, es);
                    end
                end
            end
        end
    end

    // Random ready drivers, enabled per phase.
    initial forever begin
        @(posedge m_aclk);
        #1;
        if (rand_mtrdy) m_axis_trdy = 1'($urandom_range(0, 1));
        if (rand_srdy)  stat_rdy    = ($urandom_range(0, 3) != 0);
    end

    task automatic send_beat(input logic [7:0] d, input logic l, output bit ok);
        int cyc;
        cyc = 0;
        ok  = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!ok && cyc < BOUND) begin
            @(negedge m_aclk);
            ok = s_axis_trdy;
            @(posedge m_aclk);
            #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!ok) chk("s_axis_accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int n, input bit gaps, input int stop_at);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            logic       last;
            bit         ok;
            if (i == stop_at) return;
            d    = 8'($urandom);
            last = (i == n - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge m_aclk);
                #1;
            end
            send_beat(d, last, ok);
            if (!ok) return;
            sb_data.push_back({last, d});
            if (last) begin
                exp_frames++;
                sb_stat.push_back(exp_rec(n));
            end
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        rand_mtrdy = 0;
        rand_srdy  = 0;
        @(posedge m_aclk);
        #2;
        m_axis_trdy = 1'b1;
        stat_rdy    = 1'b1;
        while ((sb_data.size() != 0 || sb_stat.size() != 0) && cyc < 4000) begin
            @(posedge m_aclk);
            cyc++;
        end
        repeat (2) @(posedge m_aclk);
        #1;
        chk("drain_complete", sb_data.size() + sb_stat.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int seen_before;

        // Reset values
        repeat (3) @(posedge m_aclk);
        @(negedge m_aclk);
        chk("rst_s_axis_trdy", s_axis_trdy, 0);
        chk("rst_m_axis_tvalid", m_axis_tvalid, 0);
        chk("rst_m_axis_tlast", m_axis_tlast, 0);
        chk("rst_m_axis_tdata", m_axis_tdata, 0);
        chk("rst_stat_valid", stat_valid, 0);
        chk("rst_stat_record", {stat_oversize, stat_runt, stat_len}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(posedge m_aclk);
        #1;
        m_sreset = 1'b0;
        @(negedge m_aclk);
        chk("trdy_low_before_first_edge", s_axis_trdy, 0);
        @(negedge m_aclk);
        chk("trdy_high_after_first_edge", s_axis_trdy, 1);
        @(posedge m_aclk);
        #1;

        // Legal, runt, oversize and single-byte frames with everything ready
        send_frame(64, 0, -1);
        drain();
        chk("frame_cnt_after_64", frame_cnt, exp_frames);
        send_frame(63, 0, -1);
        send_frame(1519, 0, -1);
        send_frame(1, 0, -1);
        send_frame(1518, 0, -1);
        drain();
        chk("frame_cnt_after_lengths", frame_cnt, exp_frames);

        // Back-to-back frames against a held status slot
        stat_rdy = 1'b0;
        fork
            begin
                send_frame(64, 0, -1);
                send_frame(64, 0, -1);
            end
            begin
                found = 0;
                for (int c = 0; c < 600 && !found; c++) begin
                    @(negedge m_aclk);
                    found = s_axis_tvalid && s_axis_tlast && stat_valid;
                end
                chk("stall_condition_reached", found, 1);
                repeat (3) begin
                    chk("stall_s_axis_trdy", s_axis_trdy, 0);
                    chk("stall_stat_len_held", stat_len, 64);
                    @(negedge m_aclk);
                end
                @(posedge m_aclk);
                #1;
                stat_rdy = 1'b1;
                @(posedge m_aclk);
                #1;
                stat_rdy = 1'b0;
                @(negedge m_aclk);
                chk("reload_keeps_stat_valid", stat_valid, 1);
                repeat (3) @(posedge m_aclk);
                #1;
                stat_rdy = 1'b1;
            end
        join
        drain();
        chk("frame_cnt_after_stall", frame_cnt, exp_frames);

        // Random downstream backpressure over a 100-byte frame, then random mixes
        rand_mtrdy = 1;
        send_frame(100, 1, -1);
        drain();
        for (int k = 0; k < 8; k++) begin
            int n;
            case ($urandom_range(0, 4))
                0:       n = 1;
                1:       n = 63;
                2:       n = 64;
                3:       n = 65;
                default: n = $urandom_range(2, 200);
            endcase
            rand_mtrdy = 1;
            rand_srdy  = 1;
            send_frame(n, 1, -1);
        end
        drain();
        chk("frame_cnt_after_random", frame_cnt, exp_frames);

        // Reset mid-frame with a record still pending
        stat_rdy = 1'b0;
        send_frame(64, 0, -1);
        send_frame(64, 0, 30);
        m_sreset = 1'b1;
        repeat (2) @(posedge m_aclk);
        #1;
        sb_data.delete();
        sb_stat.delete();
        exp_frames = 0;
        @(negedge m_aclk);
        chk("mid_rst_stat_valid", stat_valid, 0);
        chk("mid_rst_m_axis_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        @(posedge m_aclk);
        #1;
        m_sreset = 1'b0;
        stat_rdy = 1'b1;
        @(posedge m_aclk);
        #1;
        seen_before = stat_seen;
        send_frame(64, 0, -1);
        drain();
        chk("post_rst_status_count", stat_seen - seen_before, 1);
        chk("post_rst_frame_cnt", frame_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
